// File: rtl/multi_seq_param.sv
// Sequential shift-add multiplier with per-operation signed/unsigned mode, busy/valid handshake and abort.
// Optional trailing-zero skipping is enabled by defining MULTI_SEQ_ZSKIP_EN.
module multi_seq_param #(
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               tc,
   input  logic               abort,
   input  logic [WIDTH-1:0]   mlier,
   input  logic [WIDTH-1:0]   mcand,
   output logic               busy,
   output logic               valid,
   output logic [2*WIDTH-1:0] prodt
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_SIGN = 2'd2
   } state_t;

   // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
   function automatic logic [WIDTH-1:0] mag_f(input logic [WIDTH-1:0] v, input logic tc_i);
      logic [WIDTH-1:0] m;
      if (tc_i && v[WIDTH-1]) begin
         m = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         m = v;
      end
      return m;
   endfunction

   function automatic logic [PW-1:0] neg2w_f(input logic [PW-1:0] v);
      return ~v + {{(PW-1){1'b0}}, 1'b1};
   endfunction

`ifdef MULTI_SEQ_ZSKIP_EN
   // Lowest set bit position; only meaningful for a non-zero argument.
   function automatic logic [CNT_W-1:0] tz_f(input logic [WIDTH-1:0] v);
      logic [CNT_W-1:0] t;
      t = {CNT_W{1'b0}};
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (v[i]) begin
            t = CNT_W'(i);
         end else begin
            t = t;
         end
      end
      return t;
   endfunction

   logic [CNT_W-1:0] tz_s;
   logic [CNT_W:0]   shamt_s;
   logic [WIDTH-1:0] mier_shift_s;
`endif

   state_t           state_r, state_s;
   logic [WIDTH-1:0] mier_r, mier_s;
   logic [PW-1:0]    mcnd_r, mcnd_s;
   logic [PW-1:0]    acc_r, acc_s;
   logic             neg_r, neg_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             busy_r, busy_s;
   logic             valid_r, valid_s;
   logic [PW-1:0]    prodt_r, prodt_s;

   // Next-state and datapath update for the IDLE/CALC/SIGN sequencer.
   always_comb begin
      state_s = state_r;
      mier_s  = mier_r;
      mcnd_s  = mcnd_r;
      acc_s   = acc_r;
      neg_s   = neg_r;
      cnt_s   = cnt_r;
      busy_s  = busy_r;
      valid_s = 1'b0;
      prodt_s = prodt_r;
`ifdef MULTI_SEQ_ZSKIP_EN
      tz_s         = tz_f(mier_r);
      shamt_s      = {1'b0, tz_s} + {{CNT_W{1'b0}}, 1'b1};
      mier_shift_s = mier_r >> shamt_s;
`endif
      case (state_r)
         ST_IDLE: begin
            // Abort in the same cycle as start drops the request.
            if (start && !abort) begin
               mier_s  = mag_f(mlier, tc);
               mcnd_s  = {{WIDTH{1'b0}}, mag_f(mcand, tc)};
               neg_s   = tc & (mlier[WIDTH-1] ^ mcand[WIDTH-1]);
               acc_s   = {PW{1'b0}};
               cnt_s   = {CNT_W{1'b0}};
               busy_s  = 1'b1;
               state_s = ST_CALC;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (abort) begin
               busy_s  = 1'b0;
               state_s = ST_IDLE;
            end else begin
`ifdef MULTI_SEQ_ZSKIP_EN
               cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (mier_r == {WIDTH{1'b0}}) begin
                  state_s = ST_SIGN;
               end else begin
                  acc_s  = acc_r + (mcnd_r << tz_s);
                  mier_s = mier_shift_s;
                  mcnd_s = mcnd_r << shamt_s;
                  if (mier_shift_s == {WIDTH{1'b0}}) begin
                     state_s = ST_SIGN;
                  end else begin
                     state_s = ST_CALC;
                  end
               end
`else
               if (mier_r[0]) begin
                  acc_s = acc_r + mcnd_r;
               end else begin
                  acc_s = acc_r;
               end
               mier_s = mier_r >> 1;
               mcnd_s = mcnd_r << 1;
               cnt_s  = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (cnt_r == CNT_W'(WIDTH - 1)) begin
                  state_s = ST_SIGN;
               end else begin
                  state_s = ST_CALC;
               end
`endif
            end
         end
         ST_SIGN: begin
            if (abort) begin
               busy_s  = 1'b0;
               state_s = ST_IDLE;
            end else begin
               // A zero product never takes the negate path, so no -0 pattern appears.
               if (neg_r && (acc_r != {PW{1'b0}})) begin
                  prodt_s = neg2w_f(acc_r);
               end else begin
                  prodt_s = acc_r;
               end
               valid_s = 1'b1;
               busy_s  = 1'b0;
               state_s = ST_IDLE;
            end
         end
         default: begin
            busy_s  = 1'b0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         mier_r  <= {WIDTH{1'b0}};
         mcnd_r  <= {PW{1'b0}};
         acc_r   <= {PW{1'b0}};
         neg_r   <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
         prodt_r <= {PW{1'b0}};
      end else begin
         state_r <= state_s;
         mier_r  <= mier_s;
         mcnd_r  <= mcnd_s;
         acc_r   <= acc_s;
         neg_r   <= neg_s;
         cnt_r   <= cnt_s;
         busy_r  <= busy_s;
         valid_r <= valid_s;
         prodt_r <= prodt_s;
      end
   end

   assign busy  = busy_r;
   assign valid = valid_r;
   assign prodt = prodt_r;

endmodule
